// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared FSM state, requester indices and requester count for ram_port_arbiter
package ram_arb_pkg;
  typedef enum logic {ST_CLEAR, ST_RUN} state_e;
  localparam int NUM_REQ = 2;
  localparam int REQ0 = 0;
  localparam int REQ1 = 1;
endpackage

// File: rtl/rr_arbiter_2.sv
// rr_arbiter_2: two-way round-robin grant (i_en gates all grants, i_valid in, one-hot o_grant out; pointer moves to the other requester after any grant)
module rr_arbiter_2
  import ram_arb_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_valid,
  output logic [NUM_REQ-1:0] o_grant
);
  logic ptr_q, ptr_d;
  always_comb begin
    o_grant = !i_en ? '0 : &i_valid ? (ptr_q ? 2'b10 : 2'b01) : i_valid;
    ptr_d = |o_grant ? o_grant[REQ0] : ptr_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) ptr_q <= 1'b0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port registered-read RAM between two valid/ready requesters (round-robin), with optional post-reset clear sweep, per-requester read strobes and shared read data
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int                   SIZE_ADDR      = 8,
  parameter int                   SIZE_DATA      = 8,
  parameter bit                   CLEAR_ON_RESET = 1'b1,
  parameter logic [SIZE_DATA-1:0] INIT_VALUE     = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NUM_REQ-1:0]   i_req_valid,
  output logic [NUM_REQ-1:0]   o_req_ready,
  input  logic [NUM_REQ-1:0]   i_req_we,
  input  logic [SIZE_ADDR-1:0] i_req_addr0,
  input  logic [SIZE_ADDR-1:0] i_req_addr1,
  input  logic [SIZE_DATA-1:0] i_req_wdata0,
  input  logic [SIZE_DATA-1:0] i_req_wdata1,
  output logic [NUM_REQ-1:0]   o_rsp_valid,
  output logic [SIZE_DATA-1:0] o_rsp_data,
  output logic                 o_ram_rd_en,
  output logic                 o_ram_wr_en,
  output logic [SIZE_ADDR-1:0] o_ram_addr,
  output logic [SIZE_DATA-1:0] o_ram_wdata,
  input  logic [SIZE_DATA-1:0] i_ram_rdata,
  output logic                 o_init_done
);
  localparam int DEPTH = 2 ** SIZE_ADDR;
  localparam logic [SIZE_ADDR-1:0] LAST = SIZE_ADDR'(DEPTH - 1);
  state_e state_q, state_d;
  logic [SIZE_ADDR-1:0] cnt_q, cnt_d;
  logic [NUM_REQ-1:0] rsp_q, rsp_d, grant;
  logic clr, run, w, we_w;
  rr_arbiter_2 u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (run),
    .i_valid (i_req_valid),
    .o_grant (grant)
  );
  // Gating with i_rst_n forces every RAM control low while reset is held.
  always_comb begin
    clr = i_rst_n && state_q == ST_CLEAR;
    run = i_rst_n && state_q == ST_RUN;
    w = grant[REQ1];
    we_w = i_req_we[w];
    cnt_d = clr && cnt_q != LAST ? cnt_q + 1'b1 : cnt_q;
    state_d = clr && cnt_q == LAST ? ST_RUN : state_q;
    rsp_d = grant & ~i_req_we;
    o_req_ready = grant;
    o_ram_wr_en = clr || (|grant && we_w);
    o_ram_rd_en = |grant && !we_w;
    o_ram_addr = clr ? cnt_q : !(|grant) ? '0 : w ? i_req_addr1 : i_req_addr0;
    o_ram_wdata = clr ? INIT_VALUE : !(|grant) ? '0 : w ? i_req_wdata1 : i_req_wdata0;
    o_rsp_valid = rsp_q;
    o_rsp_data = i_ram_rdata;
    o_init_done = state_q == ST_RUN;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      state_q <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      cnt_q <= '0;
      rsp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rsp_q <= rsp_d;
    end
endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
Shares one single-port synchronous RAM (1 access/cycle, registered read, 1-cycle read latency) between two requesters using valid/ready handshakes and round-robin arbitration. Optional post-reset clear sweep writes INIT_VALUE to every address before requests are accepted. Read data is returned on the requester's own response channel, aligned with the RAM's registered output. Sits between client engines and the RAM macro.

Parameters:
SIZE_ADDR, 8, RAM address width; DEPTH = 2**SIZE_ADDR
SIZE_DATA, 8, RAM data width
CLEAR_ON_RESET, 1, 1 = run clear sweep after reset; 0 = go straight to RUN
INIT_VALUE, 0, SIZE_DATA-wide value written during clear sweep

Ports:
i_clk  in  1  clock
i_rst_n  in  1  async active-low reset
i_req_valid  in  2  per-requester request valid (bit0 = R0, bit1 = R1)
o_req_ready  out  2  per-requester accept; transfer when valid&ready
i_req_we  in  2  per-requester 1 = write, 0 = read
i_req_addr0 / i_req_addr1  in  SIZE_ADDR  request address
i_req_wdata0 / i_req_wdata1  in  SIZE_DATA  write data
o_rsp_valid  out  2  one-cycle read-data strobe per requester
o_rsp_data  out  SIZE_DATA  read data (shared; qualified by o_rsp_valid)
o_ram_rd_en  out  1  to RAM read enable
o_ram_wr_en  out  1  to RAM write enable
o_ram_addr  out  SIZE_ADDR  to RAM address
o_ram_wdata  out  SIZE_DATA  to RAM write data
i_ram_rdata  in  SIZE_DATA  from RAM registered read data
o_init_done  out  1  high once clear sweep finished (or immediately if CLEAR_ON_RESET=0)

Behaviour:
- Reset: the async i_rst_n, active-low, on clock i_clk is already decided. While asserted: state=ST_CLEAR (CLEAR_ON_RESET=1) else ST_RUN; clear counter=0; rr pointer=R0 priority; o_rsp_valid=0; o_init_done=0 (=1 if CLEAR_ON_RESET=0); RAM controls 0.
- FSM ST_CLEAR: each cycle o_ram_wr_en=1, o_ram_addr=counter, o_ram_wdata=INIT_VALUE, o_req_ready=0. Counter increments; on counter==DEPTH-1, next state is ST_RUN, o_init_done set next cycle. Sweep takes exactly DEPTH cycles. No wrap.
- FSM ST_RUN: one grant per cycle, combinational from i_req_valid and the rr pointer. Single valid: grant it. Both valid: grant the pointer's favourite. After any grant, the pointer moves to the other requester. No grant: pointer holds.
- o_req_ready = one-hot grant (both 0 if no valid). Ready never asserted without valid. Grant drives o_ram_* combinationally: rd_en = ~we, wr_en = we, addr/wdata muxed from winner.
- Writes: complete at accept edge; no response.
- Reads: issue at cycle T; o_rsp_valid[winner]=1 in T+1 (registered tag), o_rsp_data=i_ram_rdata passthrough. Latency 1; throughput 1 read/cycle. Responses return in issue order.
- Read after write to same address in consecutive cycles returns new data (RAM write-then-read ordering across edges).
- Reset mid-sweep or mid-read: sweep restarts at 0; a pending response is dropped (o_rsp_valid=0).
- A loser must hold request stable; it is guaranteed a grant within 2 cycles (starvation-free).

Decomposition:
- Package ram_arb_pkg: state enum (ST_CLEAR, ST_RUN), requester index constants REQ0/REQ1, NUM_REQ=2.
- Sub-module rr_arbiter_2 (pointer + one-hot grant). Leave the rest flat.

Test Plan:
- Clear sweep, SIZE_ADDR=4: release reset -> 16 cycles of wr_en with addr 0..15, data 0x00. o_req_ready=0 throughout. o_init_done=1 at cycle 17.
- R0 writes 0xA5 @0x03, then R0 reads 0x03 next cycle -> o_rsp_valid=2'b01 one cycle after read accept, o_rsp_data=0xA5.
- Both valid continuously, reads @0x01/@0x02 -> grants alternate 01,10,01,... Responses alternate with matching data.
- Only R1 valid for 3 cycles after R1 grant -> R1 granted every cycle (pointer does not block a lone requester).
- Reset asserted at sweep address 0x07 -> outputs zero immediately. After release, sweep restarts at 0x00.
- Reset asserted the cycle after a read accept -> no o_rsp_valid pulse.
